// File: rtl/icosoc_mod_triggergen_pkg.sv
// Shared definitions for the trigger generator: register map, status bit positions,
// event layout and the bus address decoder.
package icosoc_mod_triggergen_pkg;

  localparam logic [15:0] ADDR_CTRL    = 16'h0004;
  localparam logic [15:0] ADDR_COUNTER = 16'h0008;
  localparam logic [15:0] ADDR_EVENT   = 16'h000C;

  localparam int ST_RUN      = 0;
  localparam int ST_LATE     = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_EMPTY    = 3;
  localparam int ST_FULL     = 4;
  localparam int ST_FILL_LSB = 8;

  // Event word: io in [63:48], timestamp in [47:0].
  typedef struct packed {
    logic [15:0] io;
    logic [47:0] ts;
  } event_t;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_COUNTER,
    REG_EVENT,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    case (addr)
      ADDR_CTRL:    return REG_CTRL;
      ADDR_COUNTER: return REG_COUNTER;
      ADDR_EVENT:   return REG_EVENT;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/icosoc_mod_triggergen_if.sv
// icosoc control bus: held request, one-cycle done acknowledge.
interface icosoc_mod_triggergen_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  input  ctrl_rdat, ctrl_done);
  modport slave  (input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  output ctrl_rdat, ctrl_done);
endinterface

// File: rtl/icosoc_triggergen_fifo.sv
// Synchronous show-ahead event FIFO; a push into a full FIFO is taken only
// when a pop frees a slot in the same cycle.
module icosoc_triggergen_fifo
  import icosoc_mod_triggergen_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  event_t                     data_i,
  input  logic                       pop_i,
  output event_t                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);
  localparam int AW = $clog2(DEPTH);

  event_t         mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign fill_o  = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/icosoc_mod_triggergen.sv
// Trigger generator: bus decoder, half-word toggles, free-running 64-bit counter,
// timestamp compare against the FIFO head and the registered IO output.
module icosoc_mod_triggergen
  import icosoc_mod_triggergen_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int IO_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  icosoc_mod_triggergen_if.slave bus,
  output logic [IO_WIDTH-1:0]   IO
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic                done_q, run_q, late_q, ovf_q, cnt_tog_q, ev_tog_q;
  logic [31:0]         rdat_q, rdat_d, cnt_hi_q, cnt_snap_q, ev_hi_q, status;
  logic [63:0]         cnt_q, cnt_d;
  logic [IO_WIDTH-1:0] io_q;
  logic                acc, wr, rd, push, fire, full, empty;
  logic [47:0]         lag;
  logic [FW-1:0]       fill;
  reg_sel_e            sel;
  event_t              head;

  icosoc_triggergen_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (event_t'({ev_hi_q, bus.ctrl_wdat})),
    .pop_i   (fire),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    acc    = (bus.ctrl_wr || bus.ctrl_rd) && !done_q;
    wr     = acc && bus.ctrl_wr;
    rd     = acc && !bus.ctrl_wr;
    sel    = decode_addr(bus.ctrl_addr);
    push   = wr && (sel == REG_EVENT) && ev_tog_q;
    // Lag is modulo 2^48, so a clear top bit means the counter is at or past ts.
    lag    = cnt_q[47:0] - head.ts;
    fire   = !empty && run_q && !lag[47];

    status = '0;
    status[ST_FILL_LSB +: 8] = 8'(fill);
    status[ST_FULL]          = full;
    status[ST_EMPTY]         = empty;
    status[ST_OVERFLOW]      = ovf_q;
    status[ST_LATE]          = late_q;
    status[ST_RUN]           = run_q;

    rdat_d = '0;
    if (rd) begin
      case (sel)
        REG_CTRL:    rdat_d = status;
        REG_COUNTER: rdat_d = cnt_tog_q ? cnt_snap_q : cnt_q[63:32];
        REG_EVENT:   rdat_d = 32'(fill);
        default:     rdat_d = '0;
      endcase
    end

    cnt_d = run_q ? cnt_q + 64'd1 : cnt_q;
    if (wr && (sel == REG_COUNTER) && cnt_tog_q) cnt_d = {cnt_hi_q, bus.ctrl_wdat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q     <= 1'b0;
      rdat_q     <= '0;
      run_q      <= 1'b0;
      late_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_tog_q  <= 1'b0;
      ev_tog_q   <= 1'b0;
      cnt_q      <= '0;
      cnt_hi_q   <= '0;
      cnt_snap_q <= '0;
      ev_hi_q    <= '0;
      io_q       <= '0;
    end else begin
      done_q <= acc;
      rdat_q <= rdat_d;
      cnt_q  <= cnt_d;

      if (wr) begin
        case (sel)
          REG_CTRL: begin
            run_q     <= bus.ctrl_wdat[0];
            cnt_tog_q <= 1'b0;
            ev_tog_q  <= 1'b0;
            if (bus.ctrl_wdat[1]) begin
              late_q <= 1'b0;
              ovf_q  <= 1'b0;
            end
          end
          REG_COUNTER: begin
            cnt_tog_q <= !cnt_tog_q;
            if (!cnt_tog_q) cnt_hi_q <= bus.ctrl_wdat;
          end
          REG_EVENT: begin
            ev_tog_q <= !ev_tog_q;
            if (!ev_tog_q) ev_hi_q <= bus.ctrl_wdat;
          end
          default: ;
        endcase
      end

      // Reading the upper counter word freezes the lower word for the follow-up read.
      if (rd && (sel == REG_COUNTER)) begin
        cnt_tog_q <= !cnt_tog_q;
        if (!cnt_tog_q) cnt_snap_q <= cnt_q[31:0];
      end

      if (push && full && !fire) ovf_q <= 1'b1;

      if (fire) begin
        io_q <= IO_WIDTH'(head.io);
        if (lag != '0) late_q <= 1'b1;
      end
    end
  end

  assign bus.ctrl_done = done_q;
  assign bus.ctrl_rdat = rdat_q;
  assign IO            = io_q;

endmodule

// File: tb/tb_icosoc_mod_triggergen.sv
// Self-checking bench for icosoc_mod_triggergen: event-schedule reference model
// compared cycle by cycle against the IO pins, plus register and handshake checks.
module tb_icosoc_mod_triggergen;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IO;

  icosoc_mod_triggergen_if bus ();

  icosoc_mod_triggergen #(.FIFO_DEPTH(16), .IO_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IO    (IO)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_io;
  logic        m_late, m_ovf;
  logic [47:0] q_ts[$];
  logic [15:0] q_io[$];

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    bus.ctrl_wr = 1'b1; bus.ctrl_addr = a; bus.ctrl_wdat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ctrl_done === 1'b1) got = 1;
    end
    bus.ctrl_wr = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL write_ack addr=%h got no ctrl_done, expected ack within 8 cycles", a);
    end
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    bit got = 0;
    d = 'x;
    @(negedge clk);
    bus.ctrl_rd = 1'b1; bus.ctrl_addr = a;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ctrl_done === 1'b1) begin got = 1; d = bus.ctrl_rdat; end
    end
    bus.ctrl_rd = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL read_ack addr=%h got no ctrl_done, expected ack within 8 cycles", a);
    end
  endtask

  task automatic push_event(input logic [47:0] ts, input logic [15:0] io);
    bus_write(16'hC, {io, ts[47:32]});
    bus_write(16'hC, ts[31:0]);
    if (q_ts.size() < 16) begin q_ts.push_back(ts); q_io.push_back(io); end
    else m_ovf = 1'b1;
  endtask

  // Fire schedule: each event fires at the first cycle where the counter has reached
  // its ts and the previous event has already gone, one event per cycle.
  task automatic playback(input logic [63:0] c0);
    logic [31:0] r, exp_st;
    logic [15:0] exp_io;
    int          f[$];
    int          prev = -1;
    bus_write(16'h4, 32'h0);
    bus_write(16'h8, c0[63:32]);
    bus_write(16'h8, c0[31:0]);
    bus_read(16'hC, r);
    vectors++;
    if (r !== 32'(q_ts.size())) begin
      miscompares++;
      $display("FAIL event_fill got=%0d expected=%0d", r, q_ts.size());
    end
    foreach (q_ts[i]) begin
      longint t;
      t = (q_ts[i] > c0[47:0]) ? longint'(q_ts[i] - c0[47:0]) : 0;
      if (t <= prev) t = prev + 1;
      if (c0[47:0] + 48'(t) != q_ts[i]) m_late = 1'b1;
      f.push_back(int'(t));
      prev = int'(t);
    end
    bus_write(16'h4, 32'h1);
    for (int k = 1; k <= prev + 3; k++) begin
      @(posedge clk); #1;
      exp_io = m_io;
      foreach (f[i]) if (f[i] + 1 <= k) exp_io = q_io[i];
      vectors++;
      if (IO !== exp_io) begin
        miscompares++;
        $display("FAIL playback_io cycle=%0d got=%h expected=%h", k, IO, exp_io);
      end
    end
    if (q_io.size() > 0) m_io = q_io[$];
    q_ts.delete(); q_io.delete();
    bus_read(16'h4, r);
    exp_st = {16'h0, 8'h00, 3'b000, 1'b0, 1'b1, m_ovf, m_late, 1'b1};
    vectors++;
    if (r !== exp_st) begin
      miscompares++;
      $display("FAIL playback_status got=%h expected=%h", r, exp_st);
    end
    bus_write(16'h4, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({IO, bus.ctrl_done, bus.ctrl_rdat} !== 49'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got io=%h done=%b rdat=%h expected all zero", IO, bus.ctrl_done, bus.ctrl_rdat);
    end
    @(negedge clk) reset = 1'b0;
    m_io = '0; m_late = 1'b0; m_ovf = 1'b0;
    bus_read(16'h4, r);
    vectors++;
    if (r !== 32'h8) begin miscompares++; $display("FAIL reset_status got=%h expected=%h", r, 32'h8); end
    bus_read(16'h8, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL reset_counter_hi got=%h expected=0", r); end
    bus_read(16'h8, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL reset_counter_lo got=%h expected=0", r); end
  endtask

  task automatic test_registers();
    logic [31:0] r;
    bus_write(16'h4, 32'h1);
    bus_read(16'h4, r);
    vectors++;
    if (r !== 32'h9) begin miscompares++; $display("FAIL ctrl_run got=%h expected=%h", r, 32'h9); end
    bus_write(16'h4, 32'h0);
    bus_write(16'h8, 32'h1);
    bus_write(16'h8, 32'h2);
    bus_read(16'h8, r);
    vectors++;
    if (r !== 32'h1) begin miscompares++; $display("FAIL counter_hi got=%h expected=1", r); end
    bus_read(16'h8, r);
    vectors++;
    if (r !== 32'h2) begin miscompares++; $display("FAIL counter_lo got=%h expected=2", r); end
    bus_write(16'h10, 32'hFFFF_FFFF);
    bus_read(16'h10, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL undef_read got=%h expected=0", r); end
    bus_read(16'h4, r);
    vectors++;
    if (r !== 32'h8) begin miscompares++; $display("FAIL undef_no_effect got=%h expected=%h", r, 32'h8); end
  endtask

  task automatic test_handshake();
    logic exp_done;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.ctrl_rd = 1'b1; bus.ctrl_addr = 16'h4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_done = (i % 2 == 0);
      vectors++;
      if (bus.ctrl_done !== exp_done || (exp_done && bus.ctrl_rdat !== 32'h8)) begin
        miscompares++;
        $display("FAIL held_request cycle=%0d got done=%b rdat=%h expected done=%b", i, bus.ctrl_done, bus.ctrl_rdat, exp_done);
      end
    end
    bus.ctrl_rd = 1'b0;
  endtask

  task automatic test_single_event();
    push_event(48'd100, 16'hA5A5);
    playback(64'd0);
  endtask

  task automatic test_equal_ts();
    push_event(48'd10, 16'h0001);
    push_event(48'd10, 16'h0002);
    push_event(48'd20, 16'h0003);
    playback(64'd0);
    bus_write(16'h4, 32'h2);
    m_late = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic test_late_start();
    logic [31:0] r;
    push_event(48'd50, 16'hBEEF);
    playback(64'd500);
    bus_write(16'h4, 32'h3);
    m_late = 1'b0; m_ovf = 1'b0;
    bus_read(16'h4, r);
    vectors++;
    if (r !== 32'h9) begin miscompares++; $display("FAIL late_clear got=%h expected=%h", r, 32'h9); end
    bus_write(16'h4, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] r, exp_st;
    for (int i = 0; i < 17; i++) push_event(48'(i * 3 + 5), 16'(16'h100 + i));
    bus_read(16'h4, r);
    exp_st = {16'h0, 8'(q_ts.size()), 3'b000, q_ts.size() == 16, q_ts.size() == 0, m_ovf, m_late, 1'b0};
    vectors++;
    if (r !== exp_st) begin miscompares++; $display("FAIL overflow_status got=%h expected=%h", r, exp_st); end
    playback(64'd0);
    bus_write(16'h4, 32'h2);
    m_late = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic test_random();
    for (int round = 0; round < 5; round++) begin
      logic [63:0] c0;
      logic [47:0] ts;
      int          n;
      c0 = {16'($urandom), 16'h0, 32'($urandom_range(0, 40))};
      n  = $urandom_range(1, 10);
      ts = 48'($urandom_range(0, 50));
      for (int i = 0; i < n; i++) begin
        push_event(ts, 16'($urandom));
        ts = ts + 48'($urandom_range(0, 4));
      end
      playback(c0);
      bus_write(16'h4, 32'h2);
      m_late = 1'b0; m_ovf = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r;
    push_event(48'd3, 16'h1234);
    for (int i = 0; i < 4; i++) push_event(48'(1000 + i), 16'(16'h0F00 + i));
    q_ts.delete(); q_io.delete();
    bus_write(16'h4, 32'h0);
    bus_write(16'h8, 32'h0);
    bus_write(16'h8, 32'h0);
    bus_write(16'h4, 32'h1);
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (IO !== 16'h1234) begin miscompares++; $display("FAIL pre_reset_io got=%h expected=%h", IO, 16'h1234); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (IO !== 16'h0) begin miscompares++; $display("FAIL mid_reset_io got=%h expected=0", IO); end
    @(negedge clk) reset = 1'b0;
    m_io = '0; m_late = 1'b0; m_ovf = 1'b0;
    bus_read(16'h4, r);
    vectors++;
    if (r !== 32'h8) begin miscompares++; $display("FAIL mid_reset_status got=%h expected=%h", r, 32'h8); end
    bus_read(16'h8, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL mid_reset_counter_hi got=%h expected=0", r); end
    bus_read(16'h8, r);
    vectors++;
    if (r !== 32'h0) begin miscompares++; $display("FAIL mid_reset_counter_lo got=%h expected=0", r); end
  endtask

  initial begin
    bus.ctrl_wr   = 1'b0;
    bus.ctrl_rd   = 1'b0;
    bus.ctrl_addr = '0;
    bus.ctrl_wdat = '0;
    reset         = 1'b1;
    test_reset();
    test_registers();
    test_handshake();
    test_single_event();
    test_equal_ts();
    test_late_start();
    test_overflow();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
